conv_operand_streamer: RTL

- Source end of the accelerator's a/b operand handshake.
- Walks the same convolution loop nest the controller consumes, generates activation and weight memory addresses, and reads both memories (1-cycle latency).
- Presents (a_data, b_data) pairs with a_valid/b_valid, honouring a_ready/b_ready backpressure.
- A 2-entry output FIFO sustains 1 beat/cycle under continuous ready.

---
 rtl/conv_operand_streamer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/conv_operand_streamer.sv
// Walks the conv loop nest, reads activation/weight memories, streams a/b pairs.
// Build option STREAMER_ZERO_PAD_EN: zero-pad out-of-bounds taps (default: edge replicate).
module conv_operand_streamer #(
    parameter int DATA_WIDTH         = 16,
    parameter int ADDR_WIDTH         = 20,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int KERNEL_SIZE        = 3
) (
    input  logic                  clk,
    input  logic                  arst_n_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  act_mem_re,
    output logic [ADDR_WIDTH-1:0] act_mem_addr,
    input  logic [DATA_WIDTH-1:0] act_mem_rdata,
    output logic                  wgt_mem_re,
    output logic [ADDR_WIDTH-1:0] wgt_mem_addr,
    input  logic [DATA_WIDTH-1:0] wgt_mem_rdata,
    output logic                  a_valid,
    input  logic                  a_ready,
    output logic [DATA_WIDTH-1:0] a_data,
    output logic                  b_valid,
    input  logic                  b_ready,
    output logic [DATA_WIDTH-1:0] b_data
);

    localparam int P = KERNEL_SIZE / 2;
    localparam int W = FEATURE_MAP_WIDTH;
    localparam int H = FEATURE_MAP_HEIGHT;
    localparam int CIN = INPUT_NB_CHANNELS;
    localparam int K = KERNEL_SIZE;

    localparam logic [31:0] X_LAST  = 32'(FEATURE_MAP_WIDTH - 1);
    localparam logic [31:0] Y_LAST  = 32'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [31:0] CI_LAST = 32'(INPUT_NB_CHANNELS - 1);
    localparam logic [31:0] CO_LAST = 32'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [31:0] K_LAST  = 32'(KERNEL_SIZE - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0] state;

    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ci;
    logic [31:0] co;
    logic [31:0] ky;
    logic [31:0] kx;

    logic inflight;
    logic pad_q;

    logic [DATA_WIDTH-1:0] fifo_a [2];
    logic [DATA_WIDTH-1:0] fifo_b [2];
    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;

    logic       pop;
    logic       issue;
    logic       last_beat;
    logic       pad;
    logic [2:0] occ;

    logic signed [31:0] xi;
    logic signed [31:0] yi;
    logic signed [31:0] xs;
    logic signed [31:0] ys;
    logic [ADDR_WIDTH-1:0] act_addr;
    logic [ADDR_WIDTH-1:0] wgt_addr;

    assign a_valid = (count != 2'd0);
    assign b_valid = a_valid;
    assign a_data  = a_valid ? fifo_a[rd_ptr] : '0;
    assign b_data  = b_valid ? fifo_b[rd_ptr] : '0;

    assign pop = a_valid & a_ready & b_valid & b_ready;

    // Slots already claimed: stored beats plus the read in flight, less the one leaving.
    assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue = (state == STREAM) && (occ < 3'd2);

    assign last_beat = (x == X_LAST) && (y == Y_LAST) &&
                       (ci == CI_LAST) && (co == CO_LAST) &&
                       (ky == K_LAST) && (kx == K_LAST);

    assign busy = (state != IDLE);
    assign done = (state == DRAIN) && (count == 2'd0) && !inflight;

    always_comb begin
        xi  = $signed(x) + $signed(kx) - P;
        yi  = $signed(y) + $signed(ky) - P;
        xs  = xi;
        ys  = yi;
        pad = 1'b0;
`ifdef STREAMER_ZERO_PAD_EN
        pad = (xi < 0) || (xi >= W) || (yi < 0) || (yi >= H);
`else
        if (xi < 0) begin
            xs = 0;
        end else if (xi >= W) begin
            xs = W - 1;
        end
        if (yi < 0) begin
            ys = 0;
        end else if (yi >= H) begin
            ys = H - 1;
        end
`endif
        act_addr = ADDR_WIDTH'((ys * W + xs) * CIN + $signed(ci));
        wgt_addr = ADDR_WIDTH'(((co * CIN + ci) * K + ky) * K + kx);
    end

    assign act_mem_re   = issue & ~pad;
    assign act_mem_addr = act_mem_re ? act_addr : '0;
    assign wgt_mem_re   = issue;
    assign wgt_mem_addr = issue ? wgt_addr : '0;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state <= IDLE;
        end else begin
            unique case (1'b1)
                state == IDLE: begin
                    if (start) begin
                        state <= STREAM;
                    end
                end
                state == STREAM: begin
                    if (issue && last_beat) begin
                        state <= DRAIN;
                    end
                end
                state == DRAIN: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Innermost kx; the final beat wraps every counter back to zero.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            x  <= '0;
            y  <= '0;
            ci <= '0;
            co <= '0;
            ky <= '0;
            kx <= '0;
        end else if (issue) begin
            if (kx != K_LAST) begin
                kx <= kx + 32'd1;
            end else begin
                kx <= '0;
                if (ky != K_LAST) begin
                    ky <= ky + 32'd1;
                end else begin
                    ky <= '0;
                    if (co != CO_LAST) begin
                        co <= co + 32'd1;
                    end else begin
                        co <= '0;
                        if (ci != CI_LAST) begin
                            ci <= ci + 32'd1;
                        end else begin
                            ci <= '0;
                            if (y != Y_LAST) begin
                                y <= y + 32'd1;
                            end else begin
                                y <= '0;
                                if (x != X_LAST) begin
                                    x <= x + 32'd1;
                                end else begin
                                    x <= '0;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            inflight <= 1'b0;
            pad_q    <= 1'b0;
        end else begin
            inflight <= issue;
            pad_q    <= issue & pad;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int i = 0; i < 2; i++) begin
                fifo_a[i] <= '0;
                fifo_b[i] <= '0;
            end
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (inflight) begin
                fifo_a[wr_ptr] <= pad_q ? '0 : act_mem_rdata;
                fifo_b[wr_ptr] <= wgt_mem_rdata;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule
